// File: rtl/pe_result_skid_buffer_if.sv
// Valid/ready bus carrying one PE result word and its flag bits.
// The master drives the payload and valid; the slave answers with ready.
// Widths must match the DATA_WIDTH/FLAG_WIDTH of the buffer they attach to.
interface pe_result_skid_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FLAG_WIDTH = 5
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [FLAG_WIDTH-1:0] flags;

  modport master (
    output valid,
    output data,
    output flags,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  flags,
    output ready
  );
endinterface

// File: rtl/pe_result_skid_buffer.sv
// Two-entry skid buffer behind the PE shift/ALU datapath.
// The main register always drives the output bus. The skid register catches one extra
// result when downstream stalls.
// in_ready is derived only from the registered state, never from out_ready, so the
// upstream ready path stays short.
// Also counts accepted results whose zero flag (bit 1) is set, saturating at all-ones.
module pe_result_skid_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FLAG_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   clk_en,
  pe_result_skid_buffer_if.slave  in_bus,
  pe_result_skid_buffer_if.master out_bus,
  input  logic                   clr_count,
  output logic [CNT_WIDTH-1:0]   zero_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [FLAG_WIDTH-1:0] r_main_flags;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [FLAG_WIDTH-1:0] r_skid_flags;
  logic [CNT_WIDTH-1:0]  r_zero_count;

  state_t w_state_next;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_pop;
  logic   w_main_load_in;
  logic   w_main_load_skid;
  logic   w_skid_load;

  assign w_in_ready  = clk_en & (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = clk_en & in_bus.valid & w_in_ready;
  assign w_pop       = clk_en & w_out_valid & out_bus.ready;

  assign in_bus.ready  = w_in_ready;
  assign out_bus.valid = w_out_valid;
  assign out_bus.data  = r_main_data;
  assign out_bus.flags = r_main_flags;
  assign zero_count    = r_zero_count;

  // Next-state and register-load decode from the current occupancy, accept and pop
  always_comb begin
    w_state_next     = r_state;
    w_main_load_in   = 1'b0;
    w_main_load_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_next   = HALF;
          w_main_load_in = 1'b1;
        end
      end
      HALF: begin
        if (w_accept && w_pop) begin
          w_main_load_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = FULL;
          w_skid_load  = 1'b1;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the buffer
        if (w_pop) begin
          w_state_next     = HALF;
          w_main_load_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  // Occupancy state register; reset drops any buffered entries
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Main/skid payload registers; main keeps its last value when the buffer drains
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_main_data  <= '0;
      r_main_flags <= '0;
      r_skid_data  <= '0;
      r_skid_flags <= '0;
    end else begin
      if (w_main_load_in) begin
        r_main_data  <= in_bus.data;
        r_main_flags <= in_bus.flags;
      end else if (w_main_load_skid) begin
        r_main_data  <= r_skid_data;
        r_main_flags <= r_skid_flags;
      end
      if (w_skid_load) begin
        r_skid_data  <= in_bus.data;
        r_skid_flags <= in_bus.flags;
      end
    end
  end

  // Saturating count of accepted zero-flag results; clear beats increment
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_zero_count <= '0;
    end else if (clk_en) begin
      if (clr_count) begin
        r_zero_count <= '0;
      end else if (w_accept && in_bus.flags[1] && (r_zero_count != CNT_MAX)) begin
        r_zero_count <= r_zero_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pe_result_skid_buffer.sv
// Directed bench for pe_result_skid_buffer.
// Inputs change 1 time unit after a rising edge and outputs are checked at that point.
module tb_pe_result_skid_buffer;

  logic       CLK;
  logic       RESETN;
  logic       clk_en;
  logic       clr_count;
  logic [7:0] zero_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  pe_result_skid_buffer_if #(.DATA_WIDTH(16), .FLAG_WIDTH(5)) in_bus ();
  pe_result_skid_buffer_if #(.DATA_WIDTH(16), .FLAG_WIDTH(5)) out_bus ();

  pe_result_skid_buffer #(
    .DATA_WIDTH(16),
    .FLAG_WIDTH(5),
    .CNT_WIDTH (8)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .clk_en    (clk_en),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .clr_count (clr_count),
    .zero_count(zero_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; clk_en = 1'b1; clr_count = 1'b0;
    in_bus.valid = 1'b0; in_bus.data = '0; in_bus.flags = '0; out_bus.ready = 1'b0;
    tick(); tick();
    total++; if (out_bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_bus.valid); end
    total++; if (out_bus.data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_bus.data); end
    total++; if (out_bus.flags !== 5'h00) begin bad++; $display("FAIL reset_flags got=%h exp=00", out_bus.flags); end
    total++; if (zero_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", zero_count); end
    total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_bus.ready); end
    RESETN = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single();
    in_bus.valid = 1'b1; in_bus.data = 16'h0010; in_bus.flags = 5'h00; out_bus.ready = 1'b0;
    #1;
    total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL single_ready_pre got=%b exp=1", in_bus.ready); end
    tick();
    $display("push data=0010 flags=00");
    in_bus.valid = 1'b0;
    total++; if (out_bus.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_bus.valid); end
    total++; if (out_bus.data !== 16'h0010) begin bad++; $display("FAIL single_data got=%h exp=0010", out_bus.data); end
    total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", in_bus.ready); end
    out_bus.ready = 1'b1;
    tick();
    $display("pop data=0010");
    total++; if (out_bus.valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b exp=0", out_bus.valid); end
    total++; if (out_bus.data !== 16'h0010) begin bad++; $display("FAIL single_hold_data got=%h exp=0010", out_bus.data); end
  endtask

  task automatic test_stream();
    out_bus.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_bus.valid = 1'b1; in_bus.data = 16'(i); in_bus.flags = 5'h00;
      tick();
      $display("stream push data=%h", 16'(i));
      total++; if (out_bus.data !== 16'(i) || out_bus.valid !== 1'b1) begin
        bad++; $display("FAIL stream_out[%0d] got=%h/%b exp=%h/1", i, out_bus.data, out_bus.valid, 16'(i));
      end
      total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_bus.ready); end
    end
    in_bus.valid = 1'b0;
    tick();
    total++; if (out_bus.valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_bus.valid); end
  endtask

  task automatic test_backpressure();
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = 16'h00A1; in_bus.flags = 5'h11;
    tick();
    $display("push data=00a1 flags=11");
    in_bus.data = 16'h00A2; in_bus.flags = 5'h08;
    tick();
    $display("push data=00a2 flags=08");
    in_bus.valid = 1'b0;
    total++; if (in_bus.ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_bus.ready); end
    total++; if (out_bus.data !== 16'h00A1 || out_bus.flags !== 5'h11) begin
      bad++; $display("FAIL bp_head got=%h/%h exp=00a1/11", out_bus.data, out_bus.flags);
    end
    tick();
    total++; if (out_bus.data !== 16'h00A1 || out_bus.valid !== 1'b1) begin
      bad++; $display("FAIL bp_stable got=%h/%b exp=00a1/1", out_bus.data, out_bus.valid);
    end
    out_bus.ready = 1'b1;
    tick();
    $display("pop data=00a1");
    total++; if (out_bus.data !== 16'h00A2 || out_bus.flags !== 5'h08 || out_bus.valid !== 1'b1) begin
      bad++; $display("FAIL bp_second got=%h/%h/%b exp=00a2/08/1", out_bus.data, out_bus.flags, out_bus.valid);
    end
    total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_bus.ready); end
    tick();
    $display("pop data=00a2");
    total++; if (out_bus.valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_bus.valid); end
  endtask

  task automatic test_clk_en();
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = 16'h00B1; in_bus.flags = 5'h02;
    tick();
    in_bus.data = 16'h00B2;
    tick();
    exp_count += 2;
    $display("push data=00b1,00b2 flags=02");
    clk_en = 1'b0; in_bus.data = 16'h00B3; out_bus.ready = 1'b1; clr_count = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_bus.ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_bus.ready); end
      tick();
      $display("stall cycle %0d", i);
      total++; if (out_bus.data !== 16'h00B1 || out_bus.valid !== 1'b1 || zero_count !== 8'(exp_count)) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h/%b/%0d exp=00b1/1/%0d", i, out_bus.data, out_bus.valid, zero_count, exp_count);
      end
    end
    clk_en = 1'b1; clr_count = 1'b0; in_bus.valid = 1'b0;
    tick();
    $display("pop data=00b1");
    total++; if (out_bus.data !== 16'h00B2 || out_bus.valid !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%h/%b exp=00b2/1", out_bus.data, out_bus.valid);
    end
    tick();
    total++; if (out_bus.valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_bus.valid); end
  endtask

  task automatic test_saturate();
    out_bus.ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_bus.valid = 1'b1; in_bus.data = 16'h0100 + 16'(i); in_bus.flags = 5'h02;
      tick();
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      if (i == 99) begin
        total++; if (zero_count !== 8'd102) begin bad++; $display("FAIL count_mid got=%0d exp=102", zero_count); end
      end
    end
    $display("pushed 300 zero-flag results, last data=%h", out_bus.data);
    total++; if (zero_count !== 8'd255) begin bad++; $display("FAIL count_sat got=%0d exp=255", zero_count); end
    total++; if (out_bus.data !== 16'h022B) begin bad++; $display("FAIL sat_last_data got=%h exp=022b", out_bus.data); end
    clr_count = 1'b1; in_bus.data = 16'h0C01;
    tick();
    exp_count = 0;
    $display("clear with zero-flag push");
    total++; if (zero_count !== 8'd0) begin bad++; $display("FAIL count_clr got=%0d exp=0", zero_count); end
    clr_count = 1'b0; in_bus.data = 16'h0C02;
    tick();
    exp_count = 1;
    total++; if (zero_count !== 8'd1) begin bad++; $display("FAIL count_after_clr got=%0d exp=1", zero_count); end
    in_bus.valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_full();
    out_bus.ready = 1'b0;
    in_bus.valid = 1'b1; in_bus.data = 16'h00D1; in_bus.flags = 5'h00;
    tick();
    in_bus.data = 16'h00D2;
    tick();
    in_bus.valid = 1'b0;
    $display("push data=00d1,00d2 then reset");
    total++; if (in_bus.ready !== 1'b0 || zero_count !== 8'(exp_count)) begin
      bad++; $display("FAIL prereset got=%b/%0d exp=0/%0d", in_bus.ready, zero_count, exp_count);
    end
    RESETN = 1'b0; clk_en = 1'b0;
    tick();
    total++; if (out_bus.valid !== 1'b0 || out_bus.data !== 16'h0000 || zero_count !== 8'd0) begin
      bad++; $display("FAIL rst_full got=%b/%h/%0d exp=0/0000/0", out_bus.valid, out_bus.data, zero_count);
    end
    total++; if (in_bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready_noen got=%b exp=0", in_bus.ready); end
    clk_en = 1'b1;
    #1;
    total++; if (in_bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready_en got=%b exp=1", in_bus.ready); end
    RESETN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_clk_en();
    test_saturate();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
